// File: rtl/note_frame_scheduler.sv
// ============================================================================
// Module      : note_frame_scheduler
// Description : Queues note triples and commits them to the display only on
//               vsync falling edges, with minimum hold and idle blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_frame_scheduler #(
    parameter int DEPTH        = 4,
    parameter int MIN_FRAMES   = 2,
    parameter int BLANK_FRAMES = 60
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vsync,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_note_one,
    input  logic [5:0]               in_note_two,
    input  logic [5:0]               in_note_three,
    output logic [5:0]               note_one,
    output logic [5:0]               note_two,
    output logic [5:0]               note_three,
    output logic                     updated,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(MIN_FRAMES + 1);
    localparam int BW = $clog2(BLANK_FRAMES + 1);
    localparam logic [HW-1:0] c_hold_max  = HW'(MIN_FRAMES - 1);
    localparam logic [BW-1:0] c_blank_max = BW'(BLANK_FRAMES - 1);
    localparam logic [AW:0]   c_full      = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_COMMIT = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_vs_d1;
    logic            r_vs_d2;
    logic            r_pend;
    logic            r_updated;
    logic [17:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [17:0]     r_notes;
    logic [HW-1:0]   r_hold;
    logic [BW-1:0]   r_blank;

    logic w_frame_edge;
    logic w_evt;
    logic w_empty;
    logic w_push;
    logic w_load;
    logic w_count;

    assign w_frame_edge = r_vs_d2 & ~r_vs_d1;
    assign w_evt        = w_frame_edge | r_pend;
    assign w_empty      = (r_level == '0);
    assign in_ready     = (r_level != c_full);
    assign w_push       = in_valid & in_ready & ~flush;
    assign w_load       = (r_state == S_COMMIT) & ~flush & ~w_empty;
    assign w_count      = (r_state == S_WAIT) & w_evt & (w_next == S_WAIT);

    assign note_one   = r_notes[17:12];
    assign note_two   = r_notes[11:6];
    assign note_three = r_notes[5:0];
    assign updated    = r_updated;
    assign fifo_level = r_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_WAIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (w_evt) begin
                    if (!w_empty && r_hold == c_hold_max)
                        w_next = S_COMMIT;
                    else if (w_empty && r_blank == c_blank_max && (|r_notes))
                        w_next = S_CLEAR;
                end
            end
            S_COMMIT: w_next = S_WAIT;
            S_CLEAR:  w_next = S_WAIT;
            default:  w_next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_note_one, in_note_two, in_note_three};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vs_d1   <= 1'b1;
            r_vs_d2   <= 1'b1;
            r_pend    <= 1'b0;
            r_updated <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_notes   <= '0;
            r_hold    <= c_hold_max;
            r_blank   <= '0;
        end else begin
            r_vs_d1   <= vsync;
            r_vs_d2   <= r_vs_d1;
            // Edges arriving while busy are remembered for the next WAIT cycle
            r_pend    <= (r_state == S_WAIT) ? 1'b0 : (r_pend | w_frame_edge);
            r_updated <= w_load | (r_state == S_CLEAR);

            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push && !w_load)      r_level <= r_level + (AW+1)'(1);
                else if (!w_push && w_load) r_level <= r_level - (AW+1)'(1);
            end

            if (w_load)                   r_notes <= r_mem[r_rd_ptr];
            else if (r_state == S_CLEAR)  r_notes <= '0;

            if (w_load) begin
                r_hold  <= '0;
                r_blank <= '0;
            end else if (r_state == S_CLEAR) begin
                r_blank <= '0;
            end else if (w_count) begin
                if (r_hold != c_hold_max)   r_hold  <= r_hold + HW'(1);
                if (r_blank != c_blank_max) r_blank <= r_blank + BW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_note_frame_scheduler.sv
// Bench for note_frame_scheduler: frame-by-frame vector table plus directed
// sequences for latency, full-FIFO commit, flush and mid-commit reset.
`default_nettype none

module tb_note_frame_scheduler;

    localparam int DEPTH        = 4;
    localparam int MIN_FRAMES   = 2;
    localparam int BLANK_FRAMES = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vsync = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_note_one = '0;
    logic [5:0] in_note_two = '0;
    logic [5:0] in_note_three = '0;
    logic [5:0] note_one;
    logic [5:0] note_two;
    logic [5:0] note_three;
    logic       updated;
    logic [2:0] fifo_level;

    note_frame_scheduler #(
        .DEPTH        (DEPTH),
        .MIN_FRAMES   (MIN_FRAMES),
        .BLANK_FRAMES (BLANK_FRAMES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vsync         (vsync),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_note_one   (in_note_one),
        .in_note_two   (in_note_two),
        .in_note_three (in_note_three),
        .note_one      (note_one),
        .note_two      (note_two),
        .note_three    (note_three),
        .updated       (updated),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int upd_total = 0;

    always @(posedge clk) if (updated === 1'b1) upd_total++;

    typedef struct {
        bit         rst;
        bit         push;
        bit         frame;
        logic [5:0] n1, n2, n3;
        logic [5:0] e1, e2, e3;
        int         pulses;
        int         level;
    } vec_t;

    vec_t       tbl [14];
    logic [17:0] exp_seq [8];

    function automatic vec_t mk(input bit r, input bit p, input bit f,
                                input int a, input int b, input int c,
                                input int x, input int y, input int z,
                                input int pu, input int lv);
        vec_t v;
        v.rst = r; v.push = p; v.frame = f;
        v.n1 = 6'(a); v.n2 = 6'(b); v.n3 = 6'(c);
        v.e1 = 6'(x); v.e2 = 6'(y); v.e3 = 6'(z);
        v.pulses = pu; v.level = lv;
        return v;
    endfunction

    function automatic int pack(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        return int'({a, b, c});
    endfunction

    function automatic int notes();
        return int'({note_one, note_two, note_three});
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; vsync = 1'b1; flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_triple(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        int n;
        in_valid = 1'b1; in_note_one = a; in_note_two = b; in_note_three = c;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_timeout", 0, 1);
        else         @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_frame();
        vsync = 1'b0;
        repeat (8) @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int u0;

        // Reset state and commit latency
        do_reset();
        check("rst_notes", notes(), 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", in_ready, 1);
        check("rst_updated", updated, 0);
        push_triple(6'd2, 6'd4, 6'd0);
        check("t1_level_pre", fifo_level, 1);
        u0 = upd_total;
        vsync = 1'b0;
        @(negedge clk);
        check("t1_notes_e0", notes(), 0);
        @(negedge clk);
        check("t1_notes_e1", notes(), 0);
        check("t1_level_e1", fifo_level, 1);
        @(negedge clk);
        check("t1_notes_e2", notes(), pack(6'd2, 6'd4, 6'd0));
        check("t1_upd_e2", updated, 1);
        check("t1_level_e2", fifo_level, 0);
        @(negedge clk);
        check("t1_upd_e3", updated, 0);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_pulses", upd_total - u0, 1);

        // Frame table: hold time and idle blanking
        tbl[0]  = mk(1, 0, 0,  0, 0, 0,   0, 0, 0,  0, 0);
        tbl[1]  = mk(0, 1, 0,  9, 0, 0,   0, 0, 0,  0, 1);
        tbl[2]  = mk(0, 1, 0, 19, 3, 18,  0, 0, 0,  0, 2);
        tbl[3]  = mk(0, 0, 1,  0, 0, 0,   9, 0, 0,  1, 1);
        tbl[4]  = mk(0, 0, 1,  0, 0, 0,   9, 0, 0,  0, 1);
        tbl[5]  = mk(0, 0, 1,  0, 0, 0,  19, 3, 18, 1, 0);
        tbl[6]  = mk(0, 0, 1,  0, 0, 0,  19, 3, 18, 0, 0);
        tbl[7]  = mk(0, 1, 1,  4, 3, 2,   4, 3, 2,  1, 0);
        tbl[8]  = mk(0, 0, 1,  0, 0, 0,   4, 3, 2,  0, 0);
        tbl[9]  = mk(0, 0, 1,  0, 0, 0,   4, 3, 2,  0, 0);
        tbl[10] = mk(0, 0, 1,  0, 0, 0,   0, 0, 0,  1, 0);
        tbl[11] = mk(0, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0);
        tbl[12] = mk(0, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0);
        tbl[13] = mk(0, 0, 1,  0, 0, 0,   0, 0, 0,  0, 0);
        for (int i = 0; i < 14; i++) begin
            u0 = upd_total;
            if (tbl[i].rst)   do_reset();
            if (tbl[i].push)  push_triple(tbl[i].n1, tbl[i].n2, tbl[i].n3);
            if (tbl[i].frame) do_frame();
            check($sformatf("v%0d_notes", i), notes(), pack(tbl[i].e1, tbl[i].e2, tbl[i].e3));
            check($sformatf("v%0d_pulses", i), upd_total - u0, tbl[i].pulses);
            check($sformatf("v%0d_level", i), fifo_level, tbl[i].level);
        end

        // Full FIFO, push blocked during the commit cycle, order preserved
        do_reset();
        push_triple(6'd46, 6'd27, 6'd33);
        push_triple(6'd14, 6'd33, 6'd22);
        push_triple(6'd4,  6'd3,  6'd2);
        push_triple(6'd49, 6'd13, 6'd20);
        check("t3_level_full", fifo_level, 4);
        check("t3_ready_full", in_ready, 0);
        in_valid = 1'b1; in_note_one = 6'd1; in_note_two = 6'd2; in_note_three = 6'd3;
        vsync = 1'b0;
        @(negedge clk);
        check("t3_ready_e0", in_ready, 0);
        @(negedge clk);
        check("t4_level_commit", fifo_level, 4);
        check("t4_ready_commit", in_ready, 0);
        @(negedge clk);
        check("t3_level_pop", fifo_level, 3);
        check("t3_ready_pop", in_ready, 1);
        check("t3_notes_f1", notes(), pack(6'd46, 6'd27, 6'd33));
        @(negedge clk);
        check("t3_level_refill", fifo_level, 4);
        in_valid = 1'b0;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        exp_seq[0] = {6'd46, 6'd27, 6'd33};
        exp_seq[1] = {6'd14, 6'd33, 6'd22};
        exp_seq[2] = {6'd14, 6'd33, 6'd22};
        exp_seq[3] = {6'd4,  6'd3,  6'd2};
        exp_seq[4] = {6'd4,  6'd3,  6'd2};
        exp_seq[5] = {6'd49, 6'd13, 6'd20};
        exp_seq[6] = {6'd49, 6'd13, 6'd20};
        exp_seq[7] = {6'd1,  6'd2,  6'd3};
        for (int k = 0; k < 8; k++) begin
            do_frame();
            check($sformatf("t3_order_f%0d", k + 2), notes(), int'(exp_seq[k]));
        end
        check("t3_level_end", fifo_level, 0);

        // Flush with pending push, then reset during a commit
        do_reset();
        push_triple(6'd5, 6'd6, 6'd7);
        push_triple(6'd8, 6'd9, 6'd10);
        push_triple(6'd11, 6'd12, 6'd13);
        check("t6_level_pre", fifo_level, 3);
        flush = 1'b1; in_valid = 1'b1;
        in_note_one = 6'd1; in_note_two = 6'd1; in_note_three = 6'd1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("t6_level_flush", fifo_level, 0);
        check("t6_ready_flush", in_ready, 1);
        push_triple(6'd21, 6'd22, 6'd23);
        do_frame();
        check("t6_notes_a", notes(), pack(6'd21, 6'd22, 6'd23));
        push_triple(6'd30, 6'd31, 6'd32);
        do_frame();
        check("t6_notes_hold", notes(), pack(6'd21, 6'd22, 6'd23));
        check("t6_level_hold", fifo_level, 1);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_level_commit", fifo_level, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_ready", in_ready, 1);
        check("t6_rst_notes", notes(), 0);
        check("t6_rst_updated", updated, 0);
        vsync = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_post_notes", notes(), 0);
        check("t6_post_level", fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/note_frame_scheduler.md
Name: note_frame_scheduler

Overview:
- Sequences note updates into the note display datapath so displayed notes change only at frame boundaries, never mid-scan.
- Buffers note triples from the music player in a small FIFO with a valid/ready handshake.
- Commits at most one triple per vertical sync falling edge, and each triple is held for at least MIN_FRAMES frames.
- Blanks all voices to rest (0) after BLANK_FRAMES frames with no new data. Sits between the music player and note_display; its note outputs drive note_one/two/three.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- MIN_FRAMES, 2, minimum frames a committed triple stays displayed (≥1).
- BLANK_FRAMES, 60, frames with empty FIFO after a commit before outputs clear to 0 (≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- vsync  input  1  vertical sync from the DVI controller; frame boundary = 1→0 transition.
- flush  input  1  synchronous FIFO clear.
- in_valid  input  1  producer has a triple.
- in_ready  output  1  scheduler can accept.
- in_note_one  input  6  voice 1 note code.
- in_note_two  input  6  voice 2 note code.
- in_note_three  input  6  voice 3 note code.
- note_one  output  6  displayed voice 1 note.
- note_two  output  6  displayed voice 2 note.
- note_three  output  6  displayed voice 3 note.
- updated  output  1  one-cycle pulse when note outputs change.
- fifo_level  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, async):
  - FIFO empty; note outputs 0; updated 0; in_ready 1.
  - State WAIT; hold_cnt=MIN_FRAMES-1; blank_cnt=0; vsync sync flops=1.
- Sync and edge detect:
  - vsync passes through two flops d1→d2.
  - frame_edge = d2 & ~d1, registered-only and glitch-free.
- Push: occurs when in_valid & in_ready.
  - in_ready = (fifo_level != DEPTH). It is a registered-level function only, with no same-cycle pop pass-through.
  - Producer holds data stable until accepted.
- FSM states:
  - WAIT: on frame_edge:
    - If FIFO non-empty and hold_cnt ≥ MIN_FRAMES-1 → COMMIT.
    - Else if FIFO empty, blank_cnt == BLANK_FRAMES-1 and any output non-zero → CLEAR.
    - Otherwise hold_cnt and blank_cnt increment, each saturating (hold_cnt at MIN_FRAMES-1, blank_cnt at BLANK_FRAMES-1).
  - COMMIT (1 cycle): load outputs from FIFO head, pop, hold_cnt←0, blank_cnt←0, updated←1 next cycle → WAIT.
  - CLEAR (1 cycle): outputs←0, blank_cnt←0, updated←1 → WAIT. hold_cnt is unchanged.
- Latency: outputs change on the 2nd rising edge after the edge that first samples vsync low. updated is high for the cycle immediately following that change.
- Simultaneous push and pop in COMMIT: level unchanged, both entries stay correct.
- flush: FIFO emptied the same edge, and any push that cycle is dropped.
  - flush during COMMIT takes priority: no load, no updated, state→WAIT.
  - Outputs and counters are untouched.
- FIFO order is strictly FIFO and pointers wrap modulo DEPTH.
- One commit per frame maximum. Frames with MIN_FRAMES not yet elapsed leave data queued.
- A vsync edge that occurs while in COMMIT/CLEAR is still counted: it is evaluated on the following WAIT cycle, because frame_edge is held via pending flag until consumed.
- Reset assertion mid-frame or mid-COMMIT returns everything to reset values immediately.

Test Plan:
1. Reset, push {2,4,0}, one vsync falling edge → note_one=2, note_two=4, note_three=0 two clocks after edge detection; updated pulses once; fifo_level 1→0.
2. MIN_FRAMES=2: push {9,0,0} and {19,3,18} back-to-back, four vsync edges → {9,0,0} at frame 1, {19,3,18} at frame 3, no change at frames 2 and 4.
3. Fill FIFO: push 5 triples with DEPTH=4 → in_ready low after the 4th; the 5th is accepted only after the COMMIT pop; order {46,27,33},{14,33,22},{4,3,2},{49,13,20} preserved.
4. Push and vsync commit in the same cycle at level 4 → level stays 4; in_ready stays 0 that cycle.
5. BLANK_FRAMES=3: commit {4,3,2}, then 3 edges with empty FIFO → outputs 0 after 3rd edge with one updated pulse; further edges cause no pulses.
6. flush with 3 queued, then reset asserted mid-COMMIT → fifo_level 0 immediately; outputs 0, in_ready 1 asynchronously.
